// File: rtl/mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl
//
// Bridges the core's level-style memory strobes onto a registered
// request/acknowledge external bus. A core step that makes a memory access
// stalls (oRdy low) until the bus transaction reaches DONE. Read data is held
// in oRData for the instruction register and the write-back path.
//
// Build option:
//   MEMBUS_TIMEOUT_EN  when defined, a TO_W-bit watchdog aborts any access
//                      that spends TIMEOUT REQ cycles without an acknowledge.
//                      The abort zeroes oRData and sets the sticky oBusErr.
//                      When undefined, REQ waits indefinitely and oBusErr is 0.
//
// Parameters:
//   TIMEOUT  REQ cycles without acknowledge before an abort (1..2^TO_W-1)
//   TO_W     watchdog counter width
//
// Ports:
//   iClk       clock, rising edge
//   nRst       synchronous active-low reset
//   iMemRead   core read strobe (level, held for the whole step)
//   iMemWrite  core write strobe (level, held for the whole step)
//   iAddr      core address
//   iWData     core store data
//   oRdy       step-ready to the core (combinational)
//   oRData     registered read data, held until the next completed read
//   oBusAddr   registered bus address
//   oBusWData  registered bus write data
//   oBusRd     bus read request
//   oBusWr     bus write request
//   iBusAck    bus acknowledge, one cycle completes the access
//   iBusRData  bus read data, valid with iBusAck
//   oBusErr    sticky watchdog timeout flag
// -----------------------------------------------------------------------------
module mem_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  output logic        oRdy,
  output logic [31:0] oRData,
  output logic [31:0] oBusAddr,
  output logic [31:0] oBusWData,
  output logic        oBusRd,
  output logic        oBusWr,
  input  logic        iBusAck,
  input  logic [31:0] iBusRData,
  output logic        oBusErr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t state;
  logic   req;

  assign req = iMemRead | iMemWrite;

  // The core may only advance once the access has reached DONE; a step with
  // no memory access never waits.
  assign oRdy = ~req | (state == S_DONE);

`ifdef MEMBUS_TIMEOUT_EN
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] wd_cnt;
  logic            bus_err_q;

  assign oBusErr = bus_err_q;
`else
  // Without the watchdog the limit is not needed; fold it into a sink so the
  // parameter list stays identical across both builds.
  logic [TO_W-1:0] unused_timeout;

  assign unused_timeout = TO_W'(TIMEOUT);
  assign oBusErr        = 1'b0;
`endif

  // NOTE: every register here is state updated on the clock edge, so all
  // assignments are non-blocking; blocking ones would let later statements
  // see this cycle's new values and break the registered timing.
  always_ff @(posedge iClk) begin
    if (!nRst) begin
      // NOTE: data registers are cleared too, not just control, so the core
      // and the bus never observe stale address/data after a reset.
      state     <= S_IDLE;
      oBusRd    <= 1'b0;
      oBusWr    <= 1'b0;
      oBusAddr  <= '0;
      oBusWData <= '0;
      oRData    <= '0;
`ifdef MEMBUS_TIMEOUT_EN
      wd_cnt    <= '0;
      bus_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            oBusAddr  <= iAddr;
            oBusWData <= iWData;
            // The strobe registers double as the latched direction; a write
            // takes priority when both core strobes are asserted.
            oBusWr    <= iMemWrite;
            oBusRd    <= ~iMemWrite;
`ifdef MEMBUS_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
            state     <= S_REQ;
          end
        end

        S_REQ: begin
          // Completion depends only on the bus; the core strobe may drop here.
          if (iBusAck) begin
            if (oBusRd) begin
              oRData <= iBusRData;
            end
            oBusRd <= 1'b0;
            oBusWr <= 1'b0;
            state  <= S_DONE;
          end
`ifdef MEMBUS_TIMEOUT_EN
          // The count reaches TIMEOUT at this edge: give up on the access.
          else if (wd_cnt == WD_LAST) begin
            oBusRd    <= 1'b0;
            oBusWr    <= 1'b0;
            oRData    <= '0;
            bus_err_q <= 1'b1;
            state     <= S_DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_ctrl
//
// Scoreboard bench for mem_bus_ctrl. Each access pushes its expected result
// (address, data, direction, strobe length, read data, error flag) when it is
// driven; a monitor pops and compares it when the bus strobe falls (DONE).
// A bus responder acknowledges after a programmable number of wait cycles.
// Define MEMBUS_TIMEOUT_EN to exercise the watchdog with TIMEOUT=4.
// -----------------------------------------------------------------------------
module tb_mem_bus_ctrl;

  localparam int TO_LIMIT = 4;

  logic        iClk = 1'b0;
  logic        nRst;
  logic        iMemRead;
  logic        iMemWrite;
  logic [31:0] iAddr;
  logic [31:0] iWData;
  logic        oRdy;
  logic [31:0] oRData;
  logic [31:0] oBusAddr;
  logic [31:0] oBusWData;
  logic        oBusRd;
  logic        oBusWr;
  logic        iBusAck;
  logic [31:0] iBusRData;
  logic        oBusErr;

  mem_bus_ctrl #(
    .TIMEOUT(TO_LIMIT),
    .TO_W   (8)
  ) dut (
    .iClk     (iClk),
    .nRst     (nRst),
    .iMemRead (iMemRead),
    .iMemWrite(iMemWrite),
    .iAddr    (iAddr),
    .iWData   (iWData),
    .oRdy     (oRdy),
    .oRData   (oRData),
    .oBusAddr (oBusAddr),
    .oBusWData(oBusWData),
    .oBusRd   (oBusRd),
    .oBusWr   (oBusWr),
    .iBusAck  (iBusAck),
    .iBusRData(iBusRData),
    .oBusErr  (oBusErr)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          strobes;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_rdata = '0;
  logic        model_err = 1'b0;

  // Bus responder controls
  int          ack_wait = 0;
  logic [31:0] bus_data = '0;
  logic        spurious = 1'b0;
  int          rsp_cnt = 0;

  // Monitor state
  int          mon_strobes = 0;
  logic        mon_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Bus responder: acks in the (ack_wait+1)-th strobe cycle; drives a bogus
  // ack while idle when spurious is set.
  initial begin
    iBusAck   = 1'b0;
    iBusRData = '0;
    forever begin
      @(negedge iClk);
      if (oBusRd | oBusWr) begin
        if (rsp_cnt == ack_wait) begin
          iBusAck   = 1'b1;
          iBusRData = bus_data;
        end else begin
          iBusAck   = 1'b0;
          iBusRData = 32'hEEEE_EEEE;
        end
        rsp_cnt++;
      end else begin
        rsp_cnt   = 0;
        iBusAck   = spurious;
        iBusRData = spurious ? 32'hDEAD_BEEF : 32'h0;
      end
    end
  end

  // Monitor: checks the bus side during REQ and scores the access at DONE.
  initial begin
    exp_t e;
    forever begin
      @(negedge iClk);
      if (!nRst) begin
        mon_strobes = 0;
        mon_prev    = 1'b0;
      end else if (oBusRd | oBusWr) begin
        mon_strobes++;
        mon_prev = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          check("bus_dir", {oBusRd, oBusWr}, exp_q[0].wr ? 2'b01 : 2'b10);
          check("bus_addr", oBusAddr, exp_q[0].addr);
          check("bus_wdata", oBusWData, exp_q[0].wdata);
        end
      end else begin
        if (mon_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("strobe_len", mon_strobes, e.strobes);
            check("done_rdata", oRData, e.rdata);
            check("done_err", oBusErr, e.err);
            check("done_rdy", oRdy, 1);
          end
        end
        mon_prev    = 1'b0;
        mon_strobes = 0;
      end
    end
  end

  // One core step with a memory access; k = wait cycles before the ack.
  task automatic access(input logic wr, input logic both, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int k, input logic drop);
    exp_t        e;
    int          stalls;
    int          strobes;
    logic [31:0] new_rdata;
    logic        done;
    strobes   = k + 1;
    new_rdata = wr ? model_rdata : rdata;
`ifdef MEMBUS_TIMEOUT_EN
    if (k >= TO_LIMIT) begin
      strobes   = TO_LIMIT;
      new_rdata = '0;
      model_err = 1'b1;
    end
`endif
    model_rdata = new_rdata;
    e = '{wr, addr, wdata, new_rdata, strobes, model_err};
    exp_q.push_back(e);
    ack_wait = k;
    bus_data = rdata;
    @(posedge iClk);
    #1;
    iMemRead  = ~wr | both;
    iMemWrite = wr;
    iAddr     = addr;
    iWData    = wdata;
    stalls = 0;
    done   = 1'b0;
    while (!done && stalls < 200) begin
      @(negedge iClk);
      if (oRdy) done = 1'b1;
      else      stalls++;
    end
    check("access_done", done, 1);
    // Request cycle in IDLE plus every REQ cycle.
    check("stall_cycles", stalls, strobes + 1);
    if (drop) begin
      @(posedge iClk);
      #1;
      iMemRead  = 1'b0;
      iMemWrite = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    nRst      = 1'b0;
    iMemRead  = 1'b0;
    iMemWrite = 1'b0;
    iAddr     = '0;
    iWData    = '0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    check("reset_ctl", {oBusRd, oBusWr, oBusErr, oRdy}, 4'b0001);
    check("reset_addr", oBusAddr, 0);
    check("reset_wdata", oBusWData, 0);
    check("reset_rdata", oRData, 0);
    @(posedge iClk);
    #1 nRst = 1'b1;

    // Zero-wait read, then rdata must hold after the strobe drops.
    access(1'b0, 1'b0, 32'h100, 32'h0, 32'h1234_5678, 0, 1'b1);
    @(negedge iClk);
    check("read_hold", oRData, 32'h1234_5678);
    check("read_hold_rdy", oRdy, 1);

    // Wait-state write leaves rdata alone.
    access(1'b1, 1'b0, 32'h200, 32'hCAFE_F00D, 32'h5555_5555, 3, 1'b1);
    @(negedge iClk);
    check("write_rdata", oRData, 32'h1234_5678);

    // Idle passthrough with a spurious acknowledge.
    spurious = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge iClk);
      check("idle_rdy", oRdy, 1);
      check("idle_strobes", {oBusRd, oBusWr}, 2'b00);
      check("idle_rdata", oRData, 32'h1234_5678);
    end
    spurious = 1'b0;

    // Both strobes: the write wins.
    access(1'b1, 1'b1, 32'h240, 32'h0BAD_F00D, 32'hFFFF_FFFF, 1, 1'b1);

    // Back-to-back reads: request held through DONE; the second stall count
    // includes exactly one IDLE cycle before its REQ.
    access(1'b0, 1'b0, 32'h400, 32'h0, 32'hA5A5_A5A5, 0, 1'b0);
    access(1'b0, 1'b0, 32'h404, 32'h1, 32'h5A5A_5A5A, 1, 1'b1);

    // Reset during the second REQ cycle of a read.
    exp_q.push_back('{1'b0, 32'h300, 32'h0, 32'h0, 0, 1'b0});
    ack_wait = 1000;
    @(posedge iClk);
    #1;
    iMemRead = 1'b1;
    iAddr    = 32'h300;
    iWData   = 32'h0;
    @(posedge iClk);  // enters REQ
    @(posedge iClk);  // second REQ cycle
    #1;
    nRst = 1'b0;
    exp_q.delete();
    @(negedge iClk);
    check("mid_req_strobe", oBusRd, 1);
    @(negedge iClk);
    model_rdata = '0;
    check("rst_mid_rd", oBusRd, 0);
    check("rst_mid_rdata", oRData, 0);
    check("rst_mid_rdy", oRdy, 0);
    @(posedge iClk);
    #1;
    nRst     = 1'b1;
    iMemRead = 1'b0;
    access(1'b0, 1'b0, 32'h304, 32'h0, 32'h1357_9BDF, 2, 1'b1);

`ifdef MEMBUS_TIMEOUT_EN
    // Unacknowledged read aborts after TIMEOUT REQ cycles.
    access(1'b0, 1'b0, 32'h500, 32'h0, 32'h7777_7777, 1000, 1'b1);
    access(1'b0, 1'b0, 32'h504, 32'h0, 32'h2468_ACE0, 0, 1'b1);
    @(negedge iClk);
    check("err_sticky", oBusErr, 1);
`else
    // Without the watchdog a long wait still completes normally.
    access(1'b0, 1'b0, 32'h500, 32'h0, 32'h2468_ACE0, 20, 1'b1);
    @(negedge iClk);
    check("err_tied", oBusErr, 0);
`endif

    repeat (3) @(negedge iClk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Memory bus controller between the processor core and external memory. It converts the core's level-style memory read and write strobes into a registered request/acknowledge transaction on the external bus. It generates the core's step-ready signal, stalling the step counter until each access completes, and holds read data stable for the instruction register and the write-back path. With the watchdog compiled in, it also bounds each access with a timeout.

## Interface
Parameters:
- TIMEOUT, 255: REQ cycles without acknowledge before the access is aborted (watchdog builds only); legal range 1..2^TO_W-1.
- TO_W, 8: watchdog counter width.

Ports:
- iClk  in  1  clock; all state updates on the rising edge.
- nRst  in  1  reset; synchronous, active-low.
- iMemRead  in  1  core read strobe, level, held for the whole step.
- iMemWrite  in  1  core write strobe, level, held for the whole step.
- iAddr  in  32  core address, already selected between PC and the ALU result.
- iWData  in  32  core store data.
- oRdy  out  1  ready to core; high lets the step counter advance.
- oRData  out  32  read data, registered, held until the next completed read.
- oBusAddr  out  32  registered bus address.
- oBusWData  out  32  registered bus write data.
- oBusRd  out  1  bus read request.
- oBusWr  out  1  bus write request.
- iBusAck  in  1  bus acknowledge; one cycle completes the access.
- iBusRData  in  32  bus read data, valid while iBusAck is high.
- oBusErr  out  1  sticky timeout flag.

## Operation
- The FSM has three states: IDLE, REQ, DONE.
- IDLE:
  - Define req = iMemRead | iMemWrite.
  - If req is high: capture iAddr into oBusAddr and iWData into oBusWData, latch the direction, then go to REQ.
  - If both strobes are high, the write wins and the read is ignored.
- REQ:
  - oBusRd or oBusWr is high, matching the latched direction, and is driven from a register.
  - When iBusAck is high: for a read, load iBusRData into oRData; drop the strobe; go to DONE.
  - The access completes even if the core's strobe drops during REQ.
- DONE: lasts one cycle, then unconditionally returns to IDLE.
  - If req is still high in that following IDLE cycle, it starts a new access.
- oRdy = ~req | (state == DONE), combinational.
  - Steps with no memory access never stall.
  - A step with a memory access stalls until DONE.
- oRData changes only on a read acknowledge, on a timeout abort, or on reset.
  - Writes leave oRData unchanged.
- iBusAck is ignored in IDLE and DONE.
- Reset (nRst low at an edge) returns the block to IDLE from any state, including mid-REQ, and clears all registers:
  - oBusRd=0, oBusWr=0, oBusAddr=0, oBusWData=0, oRData=0, oBusErr=0, watchdog=0.
  - oRdy then follows ~req.

## Timing
- The request is sampled at edge 0.
- REQ begins in cycle 1; the bus strobe is high from cycle 1.
- With an acknowledge in cycle 1+k (k≥0):
  - DONE is in cycle 2+k.
  - oRdy is high in cycle 2+k.
  - The core advances at the end of cycle 2+k.
  - oRData is valid from cycle 2+k.
- Minimum access is 3 cycles.
- The bus strobe is high for exactly k+1 cycles and falls at the edge that enters DONE.
- oBusAddr and oBusWData are stable for the whole REQ window.

## Configuration
- The macro MEMBUS_TIMEOUT_EN controls the watchdog.
- Defined:
  - A TO_W-bit counter clears on entry to REQ and increments each REQ cycle without an acknowledge.
  - When the count reaches TIMEOUT with no acknowledge, the strobe drops, oRData is set to 32'h0000_0000, oBusErr is set, and the FSM goes to DONE.
  - oBusErr stays set until reset.
  - An acknowledge in the same cycle as the limit takes precedence: a normal completion with no error.
- Undefined:
  - There is no counter; REQ waits indefinitely.
  - oBusErr is tied to 0.
  - The TIMEOUT parameter is unused.

## Test plan
- Zero-wait read: iMemRead=1, iAddr=0x100. Ack the first REQ cycle with iBusRData=0x12345678.
  - oBusRd high exactly 1 cycle, oBusAddr=0x100.
  - oRdy low for 2 cycles, high for 1.
  - oRData=0x12345678, held after iMemRead drops.
- Wait-state write: iMemWrite=1, iAddr=0x200, iWData=0xCAFEF00D. Ack after 3 REQ cycles.
  - oBusWr high 4 cycles, with address and data stable throughout.
  - oRdy high only in DONE.
  - oRData unchanged.
- Idle passthrough: both strobes low for 10 cycles.
  - oRdy constantly 1.
  - No bus strobes.
  - A spurious iBusAck has no effect.
- Back-to-back: a read held through DONE into the following cycle.
  - A second REQ starts the cycle after DONE.
  - The two accesses are separated by exactly one IDLE cycle.
- Reset mid-REQ: drive nRst low during the second REQ cycle.
  - Next cycle: oBusRd=0, oRData=0, state IDLE.
  - After release, a new read completes normally.
- Timeout (MEMBUS_TIMEOUT_EN, TIMEOUT=4): a read with no ack.
  - oBusRd high 4 cycles.
  - Then oBusErr=1, oRData=0, one DONE cycle.
  - A later acked read succeeds, and oBusErr stays 1.
